// File: rtl/adder_memory_tally_4bit_if.sv
// ============================================================================
// adder_memory_tally_4bit_if : ballot-side and display-side signals of the tally
// Rev 1.0
// ============================================================================
`default_nettype none

interface adder_memory_tally_4bit_if;
    logic [3:0] candidate_number;
    logic       vote_cast;
    logic [3:0] rd_candidate;
    logic [3:0] candidate_out;
    logic [3:0] vote_count;
    logic [3:0] rd_count;
    logic       overflow;

    modport master (
        output candidate_number, vote_cast, rd_candidate,
        input  candidate_out, vote_count, rd_count, overflow
    );

    modport slave (
        input  candidate_number, vote_cast, rd_candidate,
        output candidate_out, vote_count, rd_count, overflow
    );
endinterface

`default_nettype wire

// File: rtl/adder_memory_tally_4bit.sv
// ============================================================================
// adder_memory_tally_4bit : 16-candidate 4-bit vote tally (ripple adder + regs)
// Optional macro TALLY_SATURATE_EN: hold a count at 15 instead of wrapping.
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      s,
    output logic      cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_4bit (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    output logic      [3:0] sum,
    output logic            carry_out
);
    logic [4:0] w_carry;

    assign w_carry[0] = 1'b0;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_fa
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (w_carry[i]),
                .s    (sum[i]),
                .cout (w_carry[i+1])
            );
        end
    endgenerate

    assign carry_out = w_carry[4];
endmodule

module tally_reg_4bit (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       write_enable,
    input  wire logic [3:0] data_in,
    output logic      [3:0] data_out
);
    logic [3:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 4'd0;
        end else if (write_enable) begin
            r_data <= data_in;
        end
    end

    assign data_out = r_data;
endmodule

module adder_memory_tally_4bit (
    input  wire logic clk,
    input  wire logic rst_n,
    adder_memory_tally_4bit_if.slave bus
);
    localparam int C_ENTRIES = 16;

    logic [3:0]           w_mem [C_ENTRIES];
    logic [C_ENTRIES-1:0] w_we;
    logic [3:0]           w_addend;
    logic [3:0]           w_sum;
    logic                 w_carry;
    logic                 w_block;
    logic [3:0]           w_cand;
    logic                 r_overflow;

    assign w_addend = bus.vote_cast ? 4'd1 : 4'd0;

    adder_4bit u_adder (
        .a         (w_mem[bus.candidate_number]),
        .b         (w_addend),
        .sum       (w_sum),
        .carry_out (w_carry)
    );

`ifdef TALLY_SATURATE_EN
    // A carry means the entry is already 15: drop the write so it sticks there.
    assign w_block = w_carry;
`else
    assign w_block = 1'b0;
`endif

    generate
        for (genvar i = 0; i < C_ENTRIES; i++) begin : g_tally
            assign w_we[i] = bus.vote_cast & ~w_block &
                             (bus.candidate_number == 4'(i));

            tally_reg_4bit u_entry (
                .clk          (clk),
                .rst_n        (rst_n),
                .write_enable (w_we[i]),
                .data_in      (w_sum),
                .data_out     (w_mem[i])
            );
        end
    endgenerate

    // The candidate latch updates on every vote, saturated or not.
    tally_reg_4bit u_cand (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (bus.vote_cast),
        .data_in      (bus.candidate_number),
        .data_out     (w_cand)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= bus.vote_cast & w_carry;
        end
    end

    assign bus.candidate_out = w_cand;
    assign bus.vote_count    = w_mem[w_cand];
    assign bus.rd_count      = w_mem[bus.rd_candidate];
    assign bus.overflow      = r_overflow;
endmodule

`default_nettype wire

// File: tb/tb_adder_memory_tally_4bit.sv
// ============================================================================
// tb_adder_memory_tally_4bit : directed + random checks against a tally model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adder_memory_tally_4bit;
`ifdef TALLY_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    adder_memory_tally_4bit_if bus ();

    adder_memory_tally_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] add_a, add_b, add_sum;
    logic       add_co;

    adder_4bit u_add (
        .a         (add_a),
        .b         (add_b),
        .sum       (add_sum),
        .carry_out (add_co)
    );

    always #5 clk = ~clk;

    // Behavioural tally: counts per candidate as plain integers.
    int tally [16];
    int m_cand;
    int m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) tally[i] <= 0;
            m_cand <= 0;
            m_ovf  <= 0;
        end else if (bus.vote_cast) begin
            m_cand <= int'(bus.candidate_number);
            m_ovf  <= (tally[bus.candidate_number] == 15) ? 1 : 0;
            if (tally[bus.candidate_number] < 15)
                tally[bus.candidate_number] <= tally[bus.candidate_number] + 1;
            else if (!SAT)
                tally[bus.candidate_number] <= 0;
        end else begin
            m_ovf <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cand, input logic v);
        @(negedge clk);
        bus.candidate_number = cand;
        bus.vote_cast        = v;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".cand"}, 32'(bus.candidate_out), 32'(m_cand));
        chk({tag, ".vcnt"}, 32'(bus.vote_count), 32'(tally[m_cand]));
        chk({tag, ".ovf"},  32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".rd"},   32'(bus.rd_count), 32'(tally[bus.rd_candidate]));
    endtask

    task automatic rd_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            bus.rd_candidate = 4'(i);
            #0.1;
            chk(tag, 32'(bus.rd_count), 32'(tally[i]));
        end
    endtask

    initial begin
        bus.candidate_number = 4'd0;
        bus.vote_cast        = 1'b0;
        bus.rd_candidate     = 4'd0;
        add_a = 4'd0;
        add_b = 4'd0;

        // Held in reset with a vote pending: nothing may be counted.
        bus.vote_cast = 1'b1;
        bus.candidate_number = 4'd6;
        repeat (2) edge_wait();
        chk("rst.cand", 32'(bus.candidate_out), 0);
        chk("rst.vcnt", 32'(bus.vote_count), 0);
        chk("rst.ovf",  32'(bus.overflow), 0);
        drive(4'd3, 1'b0);
        rst_n = 1'b1;
        edge_wait();
        rd_sweep("rst.sweep");

        // Single vote for candidate 3.
        drive(4'd3, 1'b1);
        edge_wait();
        drive(4'd3, 1'b0);
        #1;
        chk("single.cand", 32'(bus.candidate_out), 3);
        chk("single.vcnt", 32'(bus.vote_count), 1);
        bus.rd_candidate = 4'd3; #1;
        chk("single.rd3", 32'(bus.rd_count), 1);
        bus.rd_candidate = 4'd5; #1;
        chk("single.rd5", 32'(bus.rd_count), 0);

        // Five back-to-back votes for 7, then two for 2.
        for (int i = 0; i < 5; i++) begin
            drive(4'd7, 1'b1);
            edge_wait();
        end
        for (int i = 0; i < 2; i++) begin
            drive(4'd2, 1'b1);
            edge_wait();
        end
        drive(4'd0, 1'b0);
        #1;
        chk("acc.cand", 32'(bus.candidate_out), 2);
        chk("acc.vcnt", 32'(bus.vote_count), 2);
        bus.rd_candidate = 4'd7; #1;
        chk("acc.rd7", 32'(bus.rd_count), 5);
        bus.rd_candidate = 4'd2; #1;
        chk("acc.rd2", 32'(bus.rd_count), 2);

        // Idle with candidate_number toggling.
        for (int i = 0; i < 10; i++) begin
            drive(4'(i * 5), 1'b0);
            edge_wait();
        end
        chk("idle.cand", 32'(bus.candidate_out), 2);
        chk("idle.ovf",  32'(bus.overflow), 0);
        rd_sweep("idle.sweep");

        // Sixteen votes for 9 from zero reaches the limit on the last one.
        for (int i = 1; i <= 16; i++) begin
            drive(4'd9, 1'b1);
            edge_wait();
            if (i < 16) begin
                chk("lim.ovf_lo", 32'(bus.overflow), 0);
                chk("lim.cnt", 32'(bus.vote_count), 32'(i));
            end
        end
        chk("lim.ovf_hi", 32'(bus.overflow), 1);
        chk("lim.final", 32'(bus.vote_count), SAT ? 15 : 0);
        chk("lim.cand",  32'(bus.candidate_out), 9);
        drive(4'd9, 1'b0);
        edge_wait();
        chk("lim.ovf_clr", 32'(bus.overflow), 0);
        chk("lim.hold", 32'(bus.vote_count), SAT ? 15 : 0);

        // Random votes over a few candidates so limits are hit repeatedly.
        for (int n = 0; n < 400; n++) begin
            drive(4'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
            bus.rd_candidate = ($urandom_range(0, 1) != 0) ? bus.candidate_number
                                                          : 4'($urandom_range(0, 15));
            #1;
            chk("rnd.pre", 32'(bus.rd_count), 32'(tally[bus.rd_candidate]));
            edge_wait();
            check_outputs("rnd");
        end

        // Asynchronous reset mid-cycle with a vote pending.
        drive(4'd1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.cand", 32'(bus.candidate_out), 0);
        chk("mrst.vcnt", 32'(bus.vote_count), 0);
        chk("mrst.rd",   32'(bus.rd_count), 0);
        chk("mrst.ovf",  32'(bus.overflow), 0);
        edge_wait();
        chk("mrst.held", 32'(bus.vote_count), 0);
        drive(4'd4, 1'b1);
        rst_n = 1'b1;
        edge_wait();
        chk("mrst.first", 32'(bus.vote_count), 1);
        chk("mrst.fcand", 32'(bus.candidate_out), 4);
        drive(4'd4, 1'b0);
        edge_wait();
        rd_sweep("mrst.sweep");

        // Standalone adder, all operand pairs.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                add_a = 4'(a);
                add_b = 4'(b);
                #1;
                chk("add.sum", 32'(add_sum), 32'((a + b) % 16));
                chk("add.co",  32'(add_co),  32'((a + b) / 16));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
